// File: rtl/ds_mode_ctrl_if.sv
// ds_mode_ctrl_if
//   Mode-change request handshake between the register/control side and
//   the downscaler mode controller.
//   i_mode_req   : requested mode (0 bypass, 1 = 2:1, 2 = 4:1, 3 illegal)
//   i_mode_valid : request valid, held by the requester until accepted
//   o_mode_ready : controller can accept a request this cycle
//   o_mode_err   : one-cycle pulse after an illegal request was accepted
//   master = requester side, slave = controller side.
interface ds_mode_ctrl_if;
    logic [1:0] i_mode_req;
    logic       i_mode_valid;
    logic       o_mode_ready;
    logic       o_mode_err;

    modport master (
        output i_mode_req,
        output i_mode_valid,
        input  o_mode_ready,
        input  o_mode_err
    );

    modport slave (
        input  i_mode_req,
        input  i_mode_valid,
        output o_mode_ready,
        output o_mode_err
    );
endinterface

// File: rtl/ds_mode_ctrl.sv
// ds_mode_ctrl
//   Frame-synchronous mode controller for the downscaler datapath. Mode
//   requests are accepted at any time in RUN but only take effect at a frame
//   boundary (rising edge of i_vsync): the scaler is flushed for FLUSH_CYC
//   cycles, the new mode is applied, and the output stays muted until the
//   following frame boundary. Independently, the active width/height of the
//   incoming video is measured for status readback.
// Ports:
//   clk, rstn        : pixel clock, asynchronous active-low reset
//   i_vsync/i_hsync  : source syncs (hsync only kept for timing checks)
//   i_de             : source data enable
//   mode_if          : mode request handshake (slave side)
//   o_mode_active    : mode currently driving the output
//   o_path_sel       : 0 = bypass path, 1 = scaler path
//   o_scaler_en      : scaler enable
//   o_scaler_flush   : scaler pipeline / line-buffer clear
//   o_mute           : downstream forces de and data to 0
//   o_h_active       : de-high pixels in the last complete line of last frame
//   o_v_active       : lines containing de in the last frame
//   o_frame_done     : one-cycle pulse the cycle after each frame boundary
module ds_mode_ctrl #(
    parameter int CNT_W     = 12,
    parameter int FLUSH_CYC = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    ds_mode_ctrl_if.slave    mode_if,
    output logic [1:0]       o_mode_active,
    output logic             o_path_sel,
    output logic             o_scaler_en,
    output logic             o_scaler_flush,
    output logic             o_mute,
    output logic [CNT_W-1:0] o_h_active,
    output logic [CNT_W-1:0] o_v_active,
    output logic             o_frame_done
);

    typedef enum logic [1:0] {RUN, PEND, FLUSH, MUTE} state_t;

    localparam int               FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [1:0]       pend_mode;
    logic [FC_W-1:0]  flush_cnt;
    logic             mode_ready;
    logic             mode_err;
    logic             vsync_q;
    logic             de_q;
    logic             fb;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] h_last;
    logic [CNT_W-1:0] v_cnt;
    logic             unused_hsync;

    // hsync carries no information the controller needs.
    assign unused_hsync = i_hsync;

    assign fb = i_vsync & ~vsync_q;

    assign mode_if.o_mode_ready = mode_ready;
    assign mode_if.o_mode_err   = mode_err;

    // Mode switch sequencer. A request accepted in the same cycle as a frame
    // boundary lands in PEND after that boundary has gone by, so the switch
    // naturally waits for the next one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= RUN;
            pend_mode      <= 2'd0;
            flush_cnt      <= '0;
            vsync_q        <= 1'b0;
            mode_ready     <= 1'b1;
            mode_err       <= 1'b0;
            o_mode_active  <= 2'd0;
            o_path_sel     <= 1'b0;
            o_scaler_en    <= 1'b0;
            o_scaler_flush <= 1'b0;
            o_mute         <= 1'b0;
            o_frame_done   <= 1'b0;
        end else begin
            vsync_q      <= i_vsync;
            o_frame_done <= fb;
            mode_err     <= 1'b0;
            case (state)
                RUN: begin
                    if (mode_if.i_mode_valid && mode_ready) begin
                        if (mode_if.i_mode_req == 2'd3) begin
                            mode_err <= 1'b1;
                        end else if (mode_if.i_mode_req != o_mode_active) begin
                            pend_mode  <= mode_if.i_mode_req;
                            mode_ready <= 1'b0;
                            state      <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (fb) begin
                        o_scaler_flush <= 1'b1;
                        o_mute         <= 1'b1;
                        flush_cnt      <= '0;
                        state          <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Boundaries seen here are ignored; only MUTE may end the mute.
                    if (flush_cnt == FC_LAST) begin
                        o_scaler_flush <= 1'b0;
                        o_mode_active  <= pend_mode;
                        o_path_sel     <= (pend_mode != 2'd0);
                        o_scaler_en    <= (pend_mode != 2'd0);
                        state          <= MUTE;
                    end else begin
                        flush_cnt <= flush_cnt + FC_W'(1);
                    end
                end
                MUTE: begin
                    if (fb) begin
                        o_mute     <= 1'b0;
                        mode_ready <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Resolution measurement, always running. A frame boundary takes
    // priority: it publishes the totals and discards any partial line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            de_q       <= 1'b0;
            h_cnt      <= '0;
            h_last     <= '0;
            v_cnt      <= '0;
            o_h_active <= '0;
            o_v_active <= '0;
        end else begin
            de_q <= i_de;
            if (fb) begin
                o_h_active <= h_last;
                o_v_active <= v_cnt;
                h_cnt      <= '0;
                v_cnt      <= '0;
            end else if (de_q && !i_de) begin
                h_last <= h_cnt;
                h_cnt  <= '0;
                if (v_cnt != CNT_MAX) begin
                    v_cnt <= v_cnt + CNT_W'(1);
                end
            end else if (i_de && (h_cnt != CNT_MAX)) begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ds_mode_ctrl.sv
// tb_ds_mode_ctrl
//   Self-checking bench for ds_mode_ctrl. Frames of configurable geometry
//   are generated, mode requests are scheduled at chosen offsets within a
//   frame, and every output is compared each cycle against a reference model
//   that tracks the switch as a timeline relative to the frame boundary that
//   started it.
module tb_ds_mode_ctrl;

    localparam int CNT_W     = 12;
    localparam int FLUSH_CYC = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct {
        int at;
        int mode;
        int hold;
    } req_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             i_vsync = 1'b0;
    logic             i_hsync = 1'b0;
    logic             i_de = 1'b0;
    logic [1:0]       o_mode_active;
    logic             o_path_sel;
    logic             o_scaler_en;
    logic             o_scaler_flush;
    logic             o_mute;
    logic [CNT_W-1:0] o_h_active;
    logic [CNT_W-1:0] o_v_active;
    logic             o_frame_done;

    ds_mode_ctrl_if mode_if ();

    ds_mode_ctrl #(
        .CNT_W     (CNT_W),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_vsync        (i_vsync),
        .i_hsync        (i_hsync),
        .i_de           (i_de),
        .mode_if        (mode_if),
        .o_mode_active  (o_mode_active),
        .o_path_sel     (o_path_sel),
        .o_scaler_en    (o_scaler_en),
        .o_scaler_flush (o_scaler_flush),
        .o_mute         (o_mute),
        .o_h_active     (o_h_active),
        .o_v_active     (o_v_active),
        .o_frame_done   (o_frame_done)
    );

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    req_t plan[$];
    int   hold_left = 0;

    // Reference model: switch progress is "edges since the boundary that
    // started it" (m_t), -1 while waiting for that boundary.
    int m_mode, m_target, m_t, m_h, m_v, done_w, done_h;
    bit m_busy, m_ready, m_err, m_flush, m_mute, m_fd, m_vs_prev;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("mode_ready",   mode_if.o_mode_ready, m_ready);
        checkOutput("mode_err",     mode_if.o_mode_err, m_err);
        checkOutput("mode_active",  o_mode_active, m_mode);
        checkOutput("path_sel",     o_path_sel, (m_mode != 0));
        checkOutput("scaler_en",    o_scaler_en, (m_mode != 0));
        checkOutput("scaler_flush", o_scaler_flush, m_flush);
        checkOutput("mute",         o_mute, m_mute);
        checkOutput("frame_done",   o_frame_done, m_fd);
        checkOutput("h_active",     o_h_active, m_h);
        checkOutput("v_active",     o_v_active, m_v);
    endtask

    task automatic modelReset();
        m_mode = 0; m_target = 0; m_t = -1; m_h = 0; m_v = 0;
        done_w = 0; done_h = 0;
        m_busy = 0; m_ready = 1; m_err = 0; m_flush = 0; m_mute = 0;
        m_fd = 0; m_vs_prev = 0;
    endtask

    // One clock cycle: drive inputs, advance, update model, compare.
    task automatic applyStimulus(input logic vs, input logic hs, input logic de);
        logic valid_now;
        int   req_now;
        bit   fb;
        bit   accepted;
        i_vsync   = vs;
        i_hsync   = hs;
        i_de      = de;
        valid_now = mode_if.i_mode_valid;
        req_now   = int'(mode_if.i_mode_req);
        @(posedge clk);
        #1;
        fb        = vs && !m_vs_prev;
        m_vs_prev = vs;
        accepted  = valid_now && m_ready;
        m_err     = 0;
        m_fd      = fb;
        if (fb) begin
            m_h = done_w;
            m_v = done_h;
        end
        if (m_busy && m_t >= 0) begin
            m_t++;
            if (m_t == FLUSH_CYC) begin
                m_flush = 0;
                m_mode  = m_target;
            end
            if (fb && m_t > FLUSH_CYC) begin
                m_mute  = 0;
                m_busy  = 0;
                m_ready = 1;
                m_t     = -1;
            end
        end else if (m_busy && fb) begin
            m_t     = 0;
            m_flush = 1;
            m_mute  = 1;
        end
        if (accepted) begin
            if (req_now == 3) begin
                m_err = 1;
            end else if (req_now != m_mode) begin
                m_busy   = 1;
                m_target = req_now;
                m_t      = -1;
                m_ready  = 0;
            end
            mode_if.i_mode_valid = 1'b0;
            hold_left = 0;
        end else if (valid_now) begin
            hold_left--;
            if (hold_left <= 0) mode_if.i_mode_valid = 1'b0;
        end
        checkAll();
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic pulseReset();
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst_mode_ready",   mode_if.o_mode_ready, 1);
        checkOutput("rst_mode_active",  o_mode_active, 0);
        checkOutput("rst_path_sel",     o_path_sel, 0);
        checkOutput("rst_scaler_en",    o_scaler_en, 0);
        checkOutput("rst_scaler_flush", o_scaler_flush, 0);
        checkOutput("rst_mute",         o_mute, 0);
        checkOutput("rst_h_active",     o_h_active, 0);
        mode_if.i_mode_valid = 1'b0;
        hold_left = 0;
        i_vsync = 1'b0;
        i_de    = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        modelReset();
    endtask

    task automatic frameStep(inout int c, input logic vs, input logic hs, input logic de, input int rst_at);
        if (plan.size() > 0 && plan[0].at == c) begin
            mode_if.i_mode_req   = 2'(plan[0].mode);
            mode_if.i_mode_valid = 1'b1;
            hold_left = plan[0].hold;
            void'(plan.pop_front());
        end
        applyStimulus(vs, hs, de);
        if (c == rst_at) pulseReset();
        c++;
    endtask

    // Frame: 4 vsync cycles, 4 porch, h lines of w de cycles + 6 blank,
    // 4 trailing blank cycles.
    task automatic sendFrame(input int w, input int h, input int rst_at);
        int c = 0;
        for (int k = 0; k < 4; k++) frameStep(c, 1'b1, 1'b0, 1'b0, rst_at);
        for (int k = 0; k < 4; k++) frameStep(c, 1'b0, 1'b0, 1'b0, rst_at);
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) frameStep(c, 1'b0, 1'b0, 1'b1, rst_at);
            for (int b = 0; b < 6; b++) frameStep(c, 1'b0, (b < 2), 1'b0, rst_at);
        end
        for (int k = 0; k < 4; k++) frameStep(c, 1'b0, 1'b0, 1'b0, rst_at);
        done_w = (w > CNT_MAX) ? CNT_MAX : w;
        done_h = (h > CNT_MAX) ? CNT_MAX : h;
        plan.delete();
    endtask

    initial begin
        int w, h;
        mode_if.i_mode_req   = 2'd0;
        mode_if.i_mode_valid = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkAll();
        rstn = 1'b1;

        $display("[TB] idle frames 64x8");
        for (int f = 0; f < 3; f++) sendFrame(64, 8, -1);
        checkOutput("h_after_idle", o_h_active, 64);
        checkOutput("v_after_idle", o_v_active, 8);

        $display("[TB] illegal request and no-op request");
        plan.push_back('{at: 100, mode: 3, hold: 20});
        sendFrame(64, 8, -1);
        plan.push_back('{at: 100, mode: 0, hold: 20});
        sendFrame(64, 8, -1);

        $display("[TB] switch to mode 1, mode 2 offered while pending");
        plan.push_back('{at: 100, mode: 1, hold: 50});
        plan.push_back('{at: 300, mode: 2, hold: 30});
        sendFrame(64, 8, -1);
        sendFrame(64, 8, -1);
        sendFrame(64, 8, -1);
        checkOutput("mode_after_switch", o_mode_active, 1);

        $display("[TB] request accepted on the boundary cycle");
        plan.push_back('{at: 0, mode: 0, hold: 20});
        sendFrame(48, 6, -1);
        sendFrame(48, 6, -1);
        sendFrame(48, 6, -1);
        checkOutput("mode_after_fb_req", o_mode_active, 0);

        $display("[TB] reset during flush");
        plan.push_back('{at: 50, mode: 2, hold: 20});
        sendFrame(40, 4, -1);
        sendFrame(40, 4, 5);
        sendFrame(40, 4, -1);

        $display("[TB] randomized frames and requests");
        for (int f = 0; f < 10; f++) begin
            w = $urandom_range(8, 40);
            h = $urandom_range(2, 6);
            if ($urandom_range(0, 1) == 1)
                plan.push_back('{at: $urandom_range(0, 8 + h * (w + 6) + 3),
                                 mode: $urandom_range(0, 3),
                                 hold: $urandom_range(1, 40)});
            sendFrame(w, h, -1);
        end

        $display("[TB] width counter saturation");
        sendFrame(4100, 1, -1);
        sendFrame(16, 2, -1);
        sendFrame(16, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ds_mode_ctrl.md
Name: ds_mode_ctrl

Overview:
- Frame-synchronous mode controller for the downscaler datapath.
- Accepts mode-change requests from the register/control side and applies them only at frame boundaries. Mode is one of bypass, 2:1 or 4:1 decimation.
- Drives the output-path select and scaler enable/flush. Mutes output for one guard frame after each switch.
- Measures active width/height of the incoming video for status readback. Sits beside the bypass path and scaler path, ahead of the output mux.

Parameters:
- CNT_W, 12, width of resolution counters and status outputs.
- FLUSH_CYC, 16, number of cycles o_scaler_flush is held high during a switch (must be >= 1).

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- i_vsync  in  1  source vsync, active-high; its rising edge is the frame boundary
- i_hsync  in  1  source hsync, active-high (not used for counting; kept for timing checks)
- i_de  in  1  source data enable
- i_mode_req  in  2  requested mode: 0 = bypass, 1 = 2:1, 2 = 4:1, 3 = illegal
- i_mode_valid  in  1  request valid
- o_mode_ready  out  1  controller can accept a request
- o_mode_err  out  1  one-cycle pulse when an illegal request is accepted
- o_mode_active  out  2  mode currently driving the output
- o_path_sel  out  1  0 = bypass path, 1 = scaler path
- o_scaler_en  out  1  scaler enabled
- o_scaler_flush  out  1  scaler pipeline/line-buffer clear
- o_mute  out  1  downstream must force de = 0 and data = 0
- o_h_active  out  CNT_W  de-high pixels in the last complete line of the previous frame
- o_v_active  out  CNT_W  lines containing de in the previous frame
- o_frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset values:
  - o_mode_active = 0, o_path_sel = 0, o_scaler_en = 0, o_scaler_flush = 0, o_mute = 0.
  - o_mode_ready = 1, o_mode_err = 0, o_h_active = 0, o_v_active = 0, o_frame_done = 0.
  - State = RUN, all internal counters cleared.
- Frame boundary (FB): i_vsync registered once. FB = vsync_q = 0 and i_vsync = 1. o_frame_done is asserted the cycle after FB is detected.
- States: RUN, PEND, FLUSH, MUTE.
- Handshake:
  - Request accepted on the cycle where i_mode_valid and o_mode_ready are both high.
  - o_mode_ready = 1 only in RUN.
  - Requests while not ready are ignored; the requester holds valid.
- RUN, on accepted request:
  - mode 3: o_mode_err pulses the next cycle; stay in RUN.
  - mode equal to o_mode_active: no-op; stay in RUN.
  - otherwise: latch it as pend_mode and go to PEND.
- PEND: wait for FB. On FB, go to FLUSH and set o_scaler_flush = 1, o_mute = 1, flush counter = 0. If FB coincides with the cycle the request is accepted, the switch waits for the next FB.
- FLUSH:
  - Count FLUSH_CYC cycles, then deassert flush.
  - On that same edge: o_mode_active = pend_mode, o_path_sel = (pend_mode != 0), o_scaler_en = (pend_mode != 0).
  - Go to MUTE.
- MUTE: hold o_mute = 1 until the next FB. At that FB, o_mute = 0 and go to RUN. If a FB occurs during FLUSH, it does not end MUTE; only a FB seen in the MUTE state does.
- Net effect: output is muted from the first FB through the second FB after acceptance.
- Resolution measure (always running, independent of state):
  - h_cnt increments on each i_de = 1 cycle. On a de falling edge, h_last = h_cnt and h_cnt = 0.
  - v_cnt increments on each de falling edge.
  - On FB: o_h_active = h_last, o_v_active = v_cnt, then v_cnt = 0 and h_cnt = 0.
  - Counters saturate at 2^CNT_W - 1; they do not wrap.
- i_de high across FB is tolerated. Counting resumes from 0 in the new frame; the partial line is discarded.
- Async reset mid-switch returns everything to reset values immediately, i.e. bypass, unmuted.

Test Plan:
- Reset, 3 frames of 64x8 active video, no request → o_mode_active = 0, o_path_sel = 0, o_mute = 0 throughout; after the 2nd FB, o_h_active = 64 and o_v_active = 8; o_frame_done pulses once per frame.
- Request mode 1 mid-frame → o_mode_ready drops next cycle; at the next FB o_mute = 1 and o_scaler_flush is high for exactly 16 cycles; then o_mode_active = 1, o_path_sel = 1, o_scaler_en = 1; o_mute falls at the following FB; o_mode_ready = 1 again.
- Request mode 3 in RUN → o_mode_err is a single-cycle pulse; o_mode_active unchanged; o_mode_ready stays 1.
- Request mode 0 while active mode = 0 → no state change, no mute; request mode 2 while PEND → not accepted (ready = 0); after the switch completes, o_mode_active = 1.
- Request accepted on the exact FB cycle → the switch starts at the next FB, not the current one.
- Assert rstn low during FLUSH → all outputs return to reset values asynchronously; after release, o_mode_ready = 1 and the bypass path is selected.
